// File: rtl/tm_stream_pkg.sv
// Shared stream definitions for the Tsetlin-machine feature transmit and receive paths.
package tm_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tm_tx_state_e;

  localparam int TM_PACKETS_NUM = 13;
  localparam int TM_TDATA_WIDTH = 64;

  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int PAD_BITS   = TM_PACKETS_NUM * TM_TDATA_WIDTH;
  localparam int BEAT_IDX_W = beat_idx_w(TM_PACKETS_NUM);

endpackage

// File: rtl/tm_feature_packetizer_if.sv
// AXI-Stream beat bus between the feature packetizer and the inference core.
interface tm_feature_packetizer_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tm_feature_packetizer.sv
// Serializes one booleanized datapoint LSB-first into PACKETS_NUM AXI-Stream beats,
// flagging tlast on the final beat of the last datapoint of a batch.
module tm_feature_packetizer
  import tm_stream_pkg::*;
#(
  parameter int PACKETS_NUM            = TM_PACKETS_NUM,
  parameter int C_M00_AXIS_TDATA_WIDTH = TM_TDATA_WIDTH,
  parameter int FEATURE_BITS           = PAD_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FEATURE_BITS-1:0]           feat_in,
  input  logic                              feat_valid,
  input  logic                              feat_last,
  output logic                              feat_ready,
  tm_feature_packetizer_if.master           m00_axis,
  output logic [PACKETS_NUM-1:0]            beat_onehot,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] packet_counter
);

  localparam int W     = C_M00_AXIS_TDATA_WIDTH;
  localparam int PAD_W = PACKETS_NUM * W;
  localparam int IDX_W = beat_idx_w(PACKETS_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKETS_NUM - 1);

  if (FEATURE_BITS > PAD_W) begin : g_bad_width
    $error("FEATURE_BITS exceeds PACKETS_NUM*C_M00_AXIS_TDATA_WIDTH");
  end

  tm_tx_state_e           state_q;
  logic [IDX_W-1:0]       beat_idx_q;
  logic [PAD_W-1:0]       held_q;
  logic                   last_q;
  logic [PACKETS_NUM-1:0] onehot_q;
  logic [W-1:0]           count_q;

  logic [PAD_W-1:0] feat_pad;
  logic             beat_hs;
  logic             final_beat;
  logic             accept;

  always_comb begin
    feat_pad                    = '0;
    feat_pad[FEATURE_BITS-1:0]  = feat_in;
  end

  assign beat_hs    = (state_q == SEND) && m00_axis.tready;
  assign final_beat = (beat_idx_q == LAST_IDX);
  assign feat_ready = !rst && ((state_q == IDLE) || (final_beat && beat_hs));
  assign accept     = feat_valid && feat_ready;

  // The held vector shifts right one beat per handshake, so the current slice
  // [beat_idx*W +: W] always sits in the low W bits and no wide mux is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_idx_q <= '0;
      held_q     <= '0;
      last_q     <= 1'b0;
      onehot_q   <= '0;
      count_q    <= '0;
    end else begin
      if (beat_hs && final_beat) begin
        count_q <= last_q ? '0 : count_q + W'(1);
      end
      if (accept) begin
        state_q    <= SEND;
        beat_idx_q <= '0;
        held_q     <= feat_pad;
        last_q     <= feat_last;
        onehot_q   <= PACKETS_NUM'(1);
      end else if (beat_hs) begin
        if (final_beat) begin
          state_q    <= IDLE;
          beat_idx_q <= '0;
          held_q     <= '0;
          onehot_q   <= '0;
        end else begin
          beat_idx_q <= beat_idx_q + IDX_W'(1);
          held_q     <= held_q >> W;
          onehot_q   <= onehot_q << 1;
        end
      end
    end
  end

  assign m00_axis.tdata  = held_q[W-1:0];
  assign m00_axis.tvalid = (state_q == SEND);
  assign m00_axis.tlast  = (state_q == SEND) && last_q && final_beat;
  assign beat_onehot     = onehot_q;
  assign packet_counter  = count_q;

endmodule

// File: tb/tb_tm_feature_packetizer.sv
// Scoreboard bench for tm_feature_packetizer: stimulus pushes expected beats, monitors pop and compare.
module tb_tm_feature_packetizer;

  localparam int P   = 13;
  localparam int W   = 64;
  localparam int FB  = 832;
  localparam int FBB = 800;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [P-1:0] oh;
    logic [W-1:0] cnt;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [FB-1:0]  feat_a;
  logic           fv_a, fl_a, fr_a;
  logic [P-1:0]   oh_a;
  logic [W-1:0]   cnt_a;

  logic [FBB-1:0] feat_b;
  logic           fv_b, fl_b, fr_b;
  logic [P-1:0]   oh_b;
  logic [W-1:0]   cnt_b;

  tm_feature_packetizer_if #(.DATA_W(W)) axis_a ();
  tm_feature_packetizer_if #(.DATA_W(W)) axis_b ();

  tm_feature_packetizer #(
    .PACKETS_NUM(P), .C_M00_AXIS_TDATA_WIDTH(W), .FEATURE_BITS(FB)
  ) dut_a (
    .clk(clk), .rst(rst), .feat_in(feat_a), .feat_valid(fv_a), .feat_last(fl_a),
    .feat_ready(fr_a), .m00_axis(axis_a), .beat_onehot(oh_a), .packet_counter(cnt_a)
  );

  tm_feature_packetizer #(
    .PACKETS_NUM(P), .C_M00_AXIS_TDATA_WIDTH(W), .FEATURE_BITS(FBB)
  ) dut_b (
    .clk(clk), .rst(rst), .feat_in(feat_b), .feat_valid(fv_b), .feat_last(fl_b),
    .feat_ready(fr_b), .m00_axis(axis_b), .beat_onehot(oh_b), .packet_counter(cnt_b)
  );

  int tests = 0;
  int fails = 0;
  int hs_a  = 0;
  int gap_a = 0;
  bit watch_gap = 1'b0;
  int mode  = 0;
  int phase = 0;
  int bc    = 0;
  logic [3:0] bp_pat = 4'b1001;

  beat_t sb_a[$];
  beat_t sb_b[$];

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // mode 0: tready=1, 1: 1,0,0,1 pattern, 2: toggle, 3: hold 0
  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      0:       axis_a.tready = 1'b1;
      1:       axis_a.tready = bp_pat[phase % 4];
      2:       axis_a.tready = phase[0];
      default: axis_a.tready = 1'b0;
    endcase
    phase++;
  endtask

  task automatic push_a(input logic [FB-1:0] v, input logic last);
    beat_t e;
    logic [P-1:0] one;
    one = 1;
    for (int k = 0; k < P; k++) begin
      e.data = v[k*W +: W];
      e.last = last && (k == P-1);
      e.oh   = one << k;
      e.cnt  = W'(bc);
      sb_a.push_back(e);
    end
    if (last) bc = 0;
    else      bc++;
  endtask

  task automatic push_b_ones();
    beat_t e;
    logic [P-1:0] one;
    one = 1;
    for (int k = 0; k < P; k++) begin
      e.data = (k == P-1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      e.last = (k == P-1);
      e.oh   = one << k;
      e.cnt  = '0;
      sb_b.push_back(e);
    end
  endtask

  task automatic send(input bit sel, input logic [FB-1:0] v, input logic last, input bit hold);
    bit done;
    int budget;
    if (sel) begin
      push_b_ones();
      feat_b = '1; fl_b = 1'b1; fv_b = 1'b1;
    end else begin
      push_a(v, last);
      feat_a = v; fl_a = last; fv_a = 1'b1;
    end
    done = 1'b0;
    budget = 0;
    while (!done) begin
      @(negedge clk);
      if (sel ? fr_b : fr_a) begin
        done = 1'b1;
      end else if (budget > 200) begin
        tests++; fails++;
        $display("FAIL send_ready_timeout: feat_ready low for %0d cycles, expected high", budget);
        done = 1'b1;
      end
      budget++;
      tick();
    end
    if (!hold) begin
      fv_a = 1'b0;
      fv_b = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    n = 0;
    while (((sel ? sb_b.size() : sb_a.size()) > 0) && n < 400) begin
      tick();
      n++;
    end
    if ((sel ? sb_b.size() : sb_a.size()) > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats still pending, expected 0",
               sel ? sb_b.size() : sb_a.size());
    end
  endtask

  function automatic logic [FB-1:0] pattern(input logic [7:0] tag, input int dp);
    logic [FB-1:0] v;
    for (int k = 0; k < P; k++) begin
      v[k*W +: W] = {tag, 40'h0, 8'(dp), 8'(k)};
    end
    return v;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (axis_a.tvalid) begin
        if (sb_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_beat: tdata %h presented, expected no beat", axis_a.tdata);
        end else begin
          e = sb_a[0];
          chk("a_tdata",   axis_a.tdata,  e.data);
          chk("a_tlast",   W'(axis_a.tlast), W'(e.last));
          chk("a_onehot",  W'(oh_a),     W'(e.oh));
          chk("a_counter", cnt_a,        e.cnt);
          if (axis_a.tready) begin
            void'(sb_a.pop_front());
            hs_a++;
          end
        end
      end else begin
        chk("a_idle_onehot", W'(oh_a), '0);
        chk("a_idle_tlast",  W'(axis_a.tlast), '0);
        if (watch_gap && sb_a.size() > 0) gap_a++;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && axis_b.tvalid) begin
      if (sb_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_beat: tdata %h presented, expected no beat", axis_b.tdata);
      end else begin
        e = sb_b[0];
        chk("b_tdata",   axis_b.tdata, e.data);
        chk("b_tlast",   W'(axis_b.tlast), W'(e.last));
        chk("b_onehot",  W'(oh_b),    W'(e.oh));
        chk("b_counter", cnt_b,       e.cnt);
        if (axis_b.tready) void'(sb_b.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] v;
    int base;
    int n;

    rst = 1'b1;
    feat_a = '0; fv_a = 1'b0; fl_a = 1'b0;
    feat_b = '0; fv_b = 1'b0; fl_b = 1'b0;
    axis_a.tready = 1'b0;
    axis_b.tready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_tvalid",     W'(axis_a.tvalid), '0);
    chk("rst_tdata",      axis_a.tdata,      '0);
    chk("rst_tlast",      W'(axis_a.tlast),  '0);
    chk("rst_onehot",     W'(oh_a),          '0);
    chk("rst_counter",    cnt_a,             '0);
    chk("rst_feat_ready", W'(fr_a),          '0);
    chk("rst_b_ready",    W'(fr_b),          '0);
    tick();
    rst = 1'b0;

    // single datapoint
    v = '0;
    v[63:0]    = 64'h1;
    v[831:768] = 64'hCAFE;
    send(1'b0, v, 1'b1, 1'b0);
    wait_drain(1'b0);

    // backpressure 1,0,0,1
    mode = 1;
    base = hs_a;
    send(1'b0, pattern(8'hB0, 0), 1'b1, 1'b0);
    wait_drain(1'b0);
    chk("bp_handshakes", W'(hs_a - base), W'(13));
    mode = 0;

    // back-to-back batch of three
    send(1'b0, pattern(8'hD0, 0), 1'b0, 1'b1);
    gap_a = 0;
    watch_gap = 1'b1;
    send(1'b0, pattern(8'hD0, 1), 1'b0, 1'b1);
    send(1'b0, pattern(8'hD0, 2), 1'b1, 1'b0);
    wait_drain(1'b0);
    watch_gap = 1'b0;
    chk("b2b_gap_cycles", W'(gap_a), '0);
    @(negedge clk);
    chk("b2b_counter_after_tlast", cnt_a, '0);
    tick();

    // reset mid-stream at beat 5
    send(1'b0, pattern(8'hE0, 0), 1'b0, 1'b0);
    wait_drain(1'b0);
    send(1'b0, pattern(8'hE0, 1), 1'b0, 1'b0);
    base = hs_a;
    n = 0;
    while (hs_a < base + 5 && n < 100) begin
      tick();
      n++;
    end
    chk("reset_reached_beat5", W'(hs_a - base), W'(5));
    mode = 3;
    axis_a.tready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_a.delete();
    bc = 0;
    @(negedge clk);
    chk("midrst_tvalid",  W'(axis_a.tvalid), '0);
    chk("midrst_onehot",  W'(oh_a),          '0);
    chk("midrst_counter", cnt_a,             '0);
    mode = 0;
    tick();
    send(1'b0, pattern(8'hF0, 0), 1'b1, 1'b0);
    wait_drain(1'b0);

    // idle ignores tready
    mode = 2;
    repeat (8) begin
      tick();
      @(negedge clk);
      chk("idle_feat_ready", W'(fr_a),          W'(1));
      chk("idle_tvalid",     W'(axis_a.tvalid), '0);
      chk("idle_counter",    cnt_a,             W'(bc));
    end
    mode = 0;
    tick();

    // padding: 800 feature bits, all ones
    send(1'b1, '0, 1'b1, 1'b0);
    wait_drain(1'b1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tm_feature_packetizer.md
Name: tm_feature_packetizer

Overview:
- AXI-Stream transmitter that feeds the Tsetlin-machine inference core.
- Takes one booleanized datapoint as a wide feature vector over a valid/ready handshake. Serializes it LSB-first into PACKETS_NUM beats of C_M00_AXIS_TDATA_WIDTH bits.
- Drives tlast on the final beat of the last datapoint of a batch.
- Sits between the host-side feature buffer/DMA and the inference core's slave stream. Its beat one-hot and datapoint counter mirror what the core consumes.

Parameters:
- PACKETS_NUM, 13, beats per datapoint.
- C_M00_AXIS_TDATA_WIDTH, 64, beat width in bits.
- FEATURE_BITS, 832, feature-vector width. Must satisfy FEATURE_BITS <= PACKETS_NUM*C_M00_AXIS_TDATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- feat_in  in  FEATURE_BITS  datapoint feature vector.
- feat_valid  in  1  feat_in/feat_last valid.
- feat_last  in  1  datapoint is the last of its batch.
- feat_ready  out  1  packetizer can accept a datapoint this cycle.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  current beat.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tready  in  1  downstream accepts beat.
- m00_axis_tlast  out  1  final beat of final datapoint of batch.
- beat_onehot  out  PACKETS_NUM  one-hot index of the beat on the bus; 0 when tvalid is low.
- packet_counter  out  C_M00_AXIS_TDATA_WIDTH  datapoints fully sent in the current batch.

Behaviour:
- Reset (sync, rst=1 at edge): next cycle all of the following hold.
  - tvalid=0, tlast=0, tdata=0.
  - beat_onehot=0, packet_counter=0, state=IDLE, beat_idx=0.
  - feat_ready=0 while rst is high.
  - Reset mid-datapoint discards the held vector; no further beats of it are emitted.
- States:
  - IDLE: tvalid=0, feat_ready=1.
  - SEND: tvalid=1, presenting beat beat_idx.
- Accept: when feat_valid && feat_ready at edge N:
  - Latch feat_in, zero-padded to PACKETS_NUM*WIDTH, and latch feat_last.
  - beat_idx=0; state=SEND.
  - The first beat is valid at cycle N+1, so latency is 1 cycle.
- Slice rule: beat k carries padded vector bits [k*WIDTH +: WIDTH]. Beat 0 carries bits [63:0].
- Stall: while tvalid && !tready, tdata, tlast, beat_onehot and beat_idx hold stable (AXIS rule). tvalid never drops before its handshake.
- Handshake on a non-final beat (beat_idx < PACKETS_NUM-1): beat_idx increments; the next slice is presented the next cycle with no bubble.
- Handshake on the final beat (beat_idx = PACKETS_NUM-1):
  - If the held last flag = 1: packet_counter <= 0. Otherwise packet_counter <= packet_counter+1, wrapping at 2^WIDTH.
  - feat_ready is asserted combinationally in this cycle. If feat_valid is also high, the new vector loads and beat 0 follows immediately, giving back-to-back datapoints with no idle cycle.
  - Otherwise the state returns to IDLE.
- feat_ready = !rst && (state==IDLE || (beat_idx==PACKETS_NUM-1 && tvalid && tready)).
- tlast = tvalid && held_last && beat_idx==PACKETS_NUM-1.
- tready is ignored while tvalid is low.
- feat_in is ignored while feat_ready is low; it is held upstream per handshake rules.
- Throughput: exactly PACKETS_NUM accepted beats per datapoint at full rate.

Decomposition:
- Package tm_stream_pkg holds:
  - the state enum tm_tx_state_e {IDLE, SEND};
  - the localparams PAD_BITS = PACKETS_NUM*WIDTH and BEAT_IDX_W = $clog2(PACKETS_NUM).
- The same package is shared with the inference-side receive logic.
- No sub-module: the beat mux, counter and FSM stay in a single module.

Test Plan:
- Single datapoint: feat_in[63:0]=64'h1, [831:768]=64'hCAFE, feat_last=1, tready held 1.
  - tvalid rises 1 cycle after accept, followed by 13 consecutive beats.
  - Beat 0 tdata=1; beat 12 tdata=CAFE with tlast=1.
  - beat_onehot walks 13'h0001 through 13'h1000.
  - packet_counter stays 0.
- Backpressure: tready toggles 1,0,0,1 per cycle.
  - tdata, beat_onehot and tlast are stable during the 0-cycles; no beat is lost or duplicated.
  - 13 handshakes are completed in total.
- Back-to-back: three datapoints with feat_valid held high, feat_last=0,0,1.
  - 39 contiguous beats with no tvalid gap.
  - packet_counter reads 0, 1, 2 per datapoint, then 0 after the tlast handshake.
  - tlast fires only on beat 38.
- Reset mid-stream: assert rst for 1 cycle at beat 5.
  - The next cycle shows tvalid=0, beat_onehot=0, packet_counter=0.
  - A subsequent datapoint restarts at beat 0 with the correct data.
- Padding: FEATURE_BITS=800, all ones.
  - Beat 12 tdata = 64'h0000_0000_FFFF_FFFF; beats 0-11 are all ones.
- Idle ignores tready: tvalid=0 with tready toggling.
  - beat_idx and packet_counter do not change; feat_ready stays 1.
